alu_op_sequencer: RTL

// - Frames the 4-bit nibble stream from Spi_slave_module into ALU transactions (opcode, A, B).
// - Drives alu_structural operands and opcode, waits a fixed latency, captures the result and

---
 rtl/alu_op_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: frames SPI nibbles into ALU ops and hands the result back over valid/ready.
// Optional SEQ_TIMEOUT_EN aborts a partial frame after TIMEOUT_CYCLES idle cycles in GET_A/GET_B.
module alu_op_sequencer #(
    parameter int ALU_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       FPGA_clk,
    input  logic       FPGA_reset,
    input  logic [3:0] spi_data_in,
    input  logic       spi_valid_in,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_result_in,
    output logic [3:0] result_out,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       busy,
    output logic       err_opcode,
    output logic [7:0] drop_count
);
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] lat_cnt;
    logic timeout;
    logic bad_op;
    logic in_frame;
    assign in_frame = (state == GET_A) || (state == GET_B);
    assign bad_op   = (state == IDLE) && spi_valid_in && (spi_data_in[3:2] != 2'b00);
    assign busy     = (state != IDLE);
`ifdef SEQ_TIMEOUT_EN
    logic [31:0] to_cnt;
    always_ff @(posedge FPGA_clk) begin
        if (FPGA_reset || !in_frame || spi_valid_in)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 32'd1;
    end
    assign timeout = in_frame && !spi_valid_in && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // Constant false for every legal TIMEOUT_CYCLES; keeps the parameter referenced.
    assign timeout = (TIMEOUT_CYCLES < 1) && in_frame;
`endif
    always_ff @(posedge FPGA_clk) begin
        if (FPGA_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = (spi_valid_in && !bad_op) ? GET_A : IDLE;
            GET_A: state_nx = timeout ? IDLE : (spi_valid_in ? GET_B : GET_A);
            GET_B: state_nx = timeout ? IDLE : (spi_valid_in ? EXEC : GET_B);
            EXEC:  state_nx = (lat_cnt == 4'd1) ? RESP : EXEC;
            RESP:  state_nx = result_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge FPGA_clk) begin
        if (FPGA_reset) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            lat_cnt      <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            err_opcode   <= 1'b0;
            drop_count   <= '0;
        end else begin
            err_opcode <= bad_op || timeout;
            if (state == IDLE && spi_valid_in && !bad_op)
                alu_op <= spi_data_in[1:0];
            if (state == GET_A && spi_valid_in)
                alu_a <= spi_data_in;
            if (state == GET_B && spi_valid_in) begin
                alu_b   <= spi_data_in;
                lat_cnt <= 4'(ALU_LATENCY);
            end
            if (state == EXEC) begin
                lat_cnt <= lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    result_out   <= alu_result_in;
                    result_valid <= 1'b1;
                end
            end
            if (state == RESP && result_ready)
                result_valid <= 1'b0;
            // Nibbles arriving while executing or presenting are discarded, never framed.
            if ((state == EXEC || state == RESP) && spi_valid_in && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end
endmodule
